// File: rtl/xood_seq_pkg.sv
// Shared definitions for the Xoodyak command sequencer.
// Contents: sequencer state enum, idle opmode, data lane index names and the
// default data lane width.
package xood_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } seq_state_e;

  localparam int unsigned OPW_DEFAULT = 6;
  localparam int unsigned DW_DEFAULT  = 352;

  localparam logic [OPW_DEFAULT-1:0] OP_IDLE = '0;

  // Data lane indices; lane 0 is hardwired to zero data.
  localparam int unsigned L_IDLE   = 0;
  localparam int unsigned L_KEY    = 1;
  localparam int unsigned L_NONCE  = 2;
  localparam int unsigned L_ASSOC  = 3;
  localparam int unsigned L_PLAIN  = 4;
  localparam int unsigned L_CIPHER = 5;
  localparam int unsigned L_SQZ    = 6;
  localparam int unsigned L_RAT    = 7;
  localparam int unsigned L_SKY    = 8;

endpackage

// File: rtl/xood_seq_holdctr.sv
// Per-step hold counter for the command sequencer.
// Counts HOLD_CLKS-1 down to 0 while a step is presented; 'expired' flags the
// last clock of the step. For HOLD_CLKS==1 no counter exists and every clock
// is the last clock of its step.
// Ports:
//   eph1    - clock
//   reset   - asynchronous active-high reset (count -> 0)
//   clr     - synchronous clear to 0 (abort / run end)
//   load    - reload with HOLD_CLKS-1 (new step presented)
//   adv     - decrement enable (running and not stalled)
//   expired - count is 0
module xood_seq_holdctr #(
  parameter int unsigned HOLD_CLKS = 4
) (
  input  logic eph1,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic adv,
  output logic expired
);

  if (HOLD_CLKS > 1) begin : g_ctr
    localparam int unsigned CW = $clog2(HOLD_CLKS);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (load) begin
        cnt_d = CW'(HOLD_CLKS - 1);
      end else if (adv && (cnt_q != '0)) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    always_ff @(posedge eph1 or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expired = (cnt_q == '0);
  end else begin : g_none
    logic unused_ctl;
    assign unused_ctl = ^{eph1, reset, clr, load, adv};
    assign expired    = 1'b1;
  end

endmodule

// File: rtl/xood_cmd_sequencer.sv
// Programmable command sequencer driving a Xoodyak core.
// A loadable script RAM supplies one opmode per step; each step is presented
// for HOLD_CLKS clocks. Opmode bits [3:0] select one of NLANES loadable data
// lanes (lane 0 and out-of-range indices read as zero).
// Optional build macro: XOOD_SEQ_STALL_EN adds a 'stall' input that freezes
// the running step (outputs constant, hold counter frozen).
// Ports:
//   eph1, reset                  - clock, asynchronous active-high reset
//   scr_wr_en/addr/op            - script RAM write port
//   lane_wr_en/idx/data          - data lane write port
//   num_steps, loop_en           - run configuration, captured at start
//   start, abort                 - run control (abort has priority)
//   stall                        - (XOOD_SEQ_STALL_EN only) freeze running step
//   busy, done                   - running flag, end-of-run pulse
//   opmode_o, input_data_o       - core drive
//   step_idx_o, step_first_o     - step tracking
module xood_cmd_sequencer
  import xood_seq_pkg::*;
#(
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned HOLD_CLKS = 4,
  parameter int unsigned OPW       = OPW_DEFAULT,
  parameter int unsigned NLANES    = 9,
  parameter int unsigned DW        = DW_DEFAULT
) (
  input  logic                       eph1,
  input  logic                       reset,
  input  logic                       scr_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   scr_wr_addr,
  input  logic [OPW-1:0]             scr_wr_op,
  input  logic                       lane_wr_en,
  input  logic [$clog2(NLANES)-1:0]  lane_wr_idx,
  input  logic [DW-1:0]              lane_wr_data,
  input  logic [$clog2(DEPTH):0]     num_steps,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       abort,
`ifdef XOOD_SEQ_STALL_EN
  input  logic                       stall,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [OPW-1:0]             opmode_o,
  output logic [DW-1:0]              input_data_o,
  output logic [$clog2(DEPTH)-1:0]   step_idx_o,
  output logic                       step_first_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  // Storage (not reset)
  logic [OPW-1:0] script_mem [DEPTH];
  logic [DW-1:0]  lane_mem   [1:NLANES-1];

  always_ff @(posedge eph1) begin
    if (scr_wr_en) begin
      script_mem[scr_wr_addr] <= scr_wr_op;
    end
  end

  // Writes to lane 0 or beyond NLANES-1 match no entry and are dropped.
  always_ff @(posedge eph1) begin
    for (int i = 1; i < NLANES; i++) begin
      if (lane_wr_en && (32'(lane_wr_idx) == 32'(i))) begin
        lane_mem[i] <= lane_wr_data;
      end
    end
  end

  // Control state
  seq_state_e     state_q, state_d;
  logic [AW-1:0]  step_q, step_d;
  logic [AW-1:0]  last_q, last_d;
  logic           loop_q, loop_d;
  logic [OPW-1:0] opmode_q, opmode_d;
  logic           first_q, first_d;
  logic           done_q, done_d;

  logic           hold_load, hold_clr, hold_adv, hold_expired;
  logic           step_go;
  logic [SW-1:0]  ns_eff;
  logic [AW-1:0]  step_nxt;

`ifdef XOOD_SEQ_STALL_EN
  assign step_go = ~stall;
`else
  assign step_go = 1'b1;
`endif

  assign ns_eff   = (num_steps > SW'(DEPTH)) ? SW'(DEPTH) : num_steps;
  assign step_nxt = step_q + AW'(1);
  assign hold_adv = (state_q == S_RUN) && step_go;

  xood_seq_holdctr #(
    .HOLD_CLKS (HOLD_CLKS)
  ) u_holdctr (
    .eph1    (eph1),
    .reset   (reset),
    .clr     (hold_clr),
    .load    (hold_load),
    .adv     (hold_adv),
    .expired (hold_expired)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    last_d    = last_q;
    loop_d    = loop_q;
    opmode_d  = opmode_q;
    first_d   = 1'b0;
    done_d    = 1'b0;
    hold_load = 1'b0;
    hold_clr  = 1'b0;

    if (abort) begin
      state_d  = S_IDLE;
      step_d   = '0;
      opmode_d = OPW'(OP_IDLE);
      hold_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          step_d   = '0;
          opmode_d = OPW'(OP_IDLE);
          if (start) begin
            if (ns_eff == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d   = S_RUN;
              last_d    = AW'(ns_eff - SW'(1));
              loop_d    = loop_en;
              opmode_d  = script_mem[AW'(0)];
              first_d   = 1'b1;
              hold_load = 1'b1;
            end
          end
        end
        S_RUN: begin
          // Fetch happens here: script writes landing before this edge are seen.
          if (step_go && hold_expired) begin
            if (step_q != last_q) begin
              step_d    = step_nxt;
              opmode_d  = script_mem[step_nxt];
              first_d   = 1'b1;
              hold_load = 1'b1;
            end else if (loop_q) begin
              step_d    = '0;
              opmode_d  = script_mem[AW'(0)];
              first_d   = 1'b1;
              hold_load = 1'b1;
            end else begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              step_d   = '0;
              opmode_d = OPW'(OP_IDLE);
              hold_clr = 1'b1;
            end
          end
        end
        default: begin
          state_d  = S_IDLE;
          step_d   = '0;
          opmode_d = OPW'(OP_IDLE);
          hold_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge eph1 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      opmode_q <= '0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      last_q   <= last_d;
      loop_q   <= loop_d;
      opmode_q <= opmode_d;
      first_q  <= first_d;
      done_q   <= done_d;
    end
  end

  // Lane select decodes the registered opmode; idle opmode selects zero lane.
  logic [3:0]    lane_sel;
  logic [DW-1:0] lane_rd;

  assign lane_sel = opmode_q[3:0];

  always_comb begin
    lane_rd = '0;
    for (int i = 1; i < NLANES; i++) begin
      if (32'(lane_sel) == 32'(i)) begin
        lane_rd = lane_mem[i];
      end
    end
  end

  assign busy         = (state_q == S_RUN);
  assign done         = done_q;
  assign opmode_o     = opmode_q;
  assign input_data_o = lane_rd;
  assign step_idx_o   = step_q;
  assign step_first_o = first_q;

endmodule

// File: tb/tb_xood_cmd_sequencer.sv
// Self-checking bench for xood_cmd_sequencer (default parameters).
// Expected outputs come from a cycle-index model: for cycle k after start,
// step = (k / HOLD) mod n, first = (k mod HOLD == 0), done on cycle n*HOLD.
module tb_xood_cmd_sequencer;

  localparam int DEPTH  = 128;
  localparam int HOLD   = 4;
  localparam int OPW    = 6;
  localparam int NLANES = 9;
  localparam int DW     = 352;
  localparam int AW     = 7;
  localparam int LIW    = 4;
  localparam int SW     = 8;
  localparam int VW     = 3 + AW + OPW + DW;

  logic              eph1 = 1'b0;
  logic              reset;
  logic              scr_wr_en;
  logic [AW-1:0]     scr_wr_addr;
  logic [OPW-1:0]    scr_wr_op;
  logic              lane_wr_en;
  logic [LIW-1:0]    lane_wr_idx;
  logic [DW-1:0]     lane_wr_data;
  logic [SW-1:0]     num_steps;
  logic              loop_en;
  logic              start;
  logic              abort;
`ifdef XOOD_SEQ_STALL_EN
  logic              stall;
`endif
  logic              busy;
  logic              done;
  logic [OPW-1:0]    opmode_o;
  logic [DW-1:0]     input_data_o;
  logic [AW-1:0]     step_idx_o;
  logic              step_first_o;

  logic [VW-1:0]     got;
  assign got = {busy, done, step_first_o, step_idx_o, opmode_o, input_data_o};

  int vectors = 0;
  int miscompares = 0;

  logic [OPW-1:0] script_m [DEPTH];
  logic [DW-1:0]  lanes_m  [NLANES];

  always #5 eph1 = ~eph1;

  xood_cmd_sequencer dut (
    .eph1         (eph1),
    .reset        (reset),
    .scr_wr_en    (scr_wr_en),
    .scr_wr_addr  (scr_wr_addr),
    .scr_wr_op    (scr_wr_op),
    .lane_wr_en   (lane_wr_en),
    .lane_wr_idx  (lane_wr_idx),
    .lane_wr_data (lane_wr_data),
    .num_steps    (num_steps),
    .loop_en      (loop_en),
    .start        (start),
    .abort        (abort),
`ifdef XOOD_SEQ_STALL_EN
    .stall        (stall),
`endif
    .busy         (busy),
    .done         (done),
    .opmode_o     (opmode_o),
    .input_data_o (input_data_o),
    .step_idx_o   (step_idx_o),
    .step_first_o (step_first_o)
  );

  task automatic tick;
    @(posedge eph1);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] lane_model(int idx);
    if (idx >= 1 && idx < NLANES) return lanes_m[idx];
    return '0;
  endfunction

  // Expected {busy,done,first,step,opmode,data} on cycle k after start.
  function automatic logic [VW-1:0] exp_vec(int k, int n, bit lp);
    logic [VW-1:0]  v;
    logic [OPW-1:0] op;
    int ne, total, s;
    ne    = (n > DEPTH) ? DEPTH : n;
    total = ne * HOLD;
    v     = '0;
    if (ne == 0) begin
      if (k == 0) v[VW-2] = 1'b1;
    end else if (lp || k < total) begin
      s  = (k / HOLD) % ne;
      op = script_m[s];
      v  = {1'b1, 1'b0, ((k % HOLD) == 0), AW'(s), op, lane_model(int'(op[3:0]))};
    end else if (k == total) begin
      v[VW-2] = 1'b1;
    end
    return v;
  endfunction

  task automatic wr_script(int a, logic [OPW-1:0] op);
    scr_wr_en = 1'b1; scr_wr_addr = AW'(a); scr_wr_op = op;
    tick;
    scr_wr_en = 1'b0;
    script_m[a] = op;
  endtask

  task automatic wr_lane(int i, logic [DW-1:0] d);
    lane_wr_en = 1'b1; lane_wr_idx = LIW'(i); lane_wr_data = d;
    tick;
    lane_wr_en = 1'b0;
    if (i >= 1 && i < NLANES) lanes_m[i] = d;
  endtask

  task automatic do_start(int n, bit lp);
    num_steps = SW'(n); loop_en = lp; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic init_memories;
    for (int a = 0; a < DEPTH; a++) wr_script(a, OPW'($urandom_range(0, 63)));
    for (int i = 1; i < NLANES; i++) wr_lane(i, rand_dw());
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_idle got=%h exp=0", got);
    end
    @(negedge eph1);
    reset = 1'b0;
    tick;
    init_memories();
    wr_script(0, 6'h01); wr_script(1, 6'h02); wr_script(2, 6'h03);
    do_start(3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (got !== exp_vec(k, 3, 1'b0)) begin
        miscompares++;
        $display("FAIL reset_prerun k=%0d got=%h exp=%h", k, got, exp_vec(k, 3, 1'b0));
      end
      tick;
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_async got=%h exp=0", got);
    end
    #2;
    reset = 1'b0;
    tick;
    tick;
    vectors++;
    if (got !== '0) begin
      miscompares++;
      $display("FAIL reset_stays_idle got=%h exp=0", got);
    end
  endtask

  task automatic test_basic;
    int busy_cnt;
    busy_cnt = 0;
    wr_lane(xood_seq_pkg::L_KEY, rand_dw());
    wr_lane(xood_seq_pkg::L_NONCE, rand_dw());
    wr_lane(xood_seq_pkg::L_ASSOC, rand_dw());
    wr_script(0, 6'h01); wr_script(1, 6'h02); wr_script(2, 6'h03);
    do_start(3, 1'b0);
    for (int k = 0; k < 3 * HOLD + 4; k++) begin
      vectors++;
      if (got !== exp_vec(k, 3, 1'b0)) begin
        miscompares++;
        $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp_vec(k, 3, 1'b0));
      end
      if (busy === 1'b1) busy_cnt++;
      tick;
    end
    vectors++;
    if (busy_cnt !== 3 * HOLD) begin
      miscompares++;
      $display("FAIL basic_busy_len got=%0d exp=%0d", busy_cnt, 3 * HOLD);
    end
  endtask

  task automatic test_hash_mask;
    wr_lane(xood_seq_pkg::L_ASSOC, rand_dw());
    wr_script(0, 6'h10); wr_script(1, 6'h13);
    do_start(2, 1'b0);
    for (int k = 0; k < 2 * HOLD + 3; k++) begin
      vectors++;
      if (got !== exp_vec(k, 2, 1'b0)) begin
        miscompares++;
        $display("FAIL hash_mask k=%0d got=%h exp=%h", k, got, exp_vec(k, 2, 1'b0));
      end
      tick;
    end
  endtask

  task automatic test_loop_abort;
    wr_script(0, OPW'($urandom_range(0, 63)));
    wr_script(1, OPW'($urandom_range(0, 63)));
    do_start(2, 1'b1);
    for (int k = 0; k < 17; k++) begin
      vectors++;
      if (got !== exp_vec(k, 2, 1'b1)) begin
        miscompares++;
        $display("FAIL loop k=%0d got=%h exp=%h", k, got, exp_vec(k, 2, 1'b1));
      end
      if (k < 16) tick;
    end
    // abort together with start: abort must win
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got !== '0) begin
        miscompares++;
        $display("FAIL loop_abort k=%0d got=%h exp=0", k, got);
      end
      tick;
    end
  endtask

  task automatic test_edge;
    // zero-length run
    do_start(0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (got !== exp_vec(k, 0, 1'b0)) begin
        miscompares++;
        $display("FAIL zero_steps k=%0d got=%h exp=%h", k, got, exp_vec(k, 0, 1'b0));
      end
      tick;
    end
    // out-of-range lane index
    wr_script(0, 6'h0F);
    do_start(1, 1'b0);
    for (int k = 0; k < HOLD + 2; k++) begin
      vectors++;
      if (got !== exp_vec(k, 1, 1'b0)) begin
        miscompares++;
        $display("FAIL lane_oob k=%0d got=%h exp=%h", k, got, exp_vec(k, 1, 1'b0));
      end
      tick;
    end
    // start (with new config) during RUN is ignored
    for (int a = 0; a < 3; a++) wr_script(a, OPW'($urandom_range(0, 63)));
    do_start(3, 1'b0);
    for (int k = 0; k < 3 * HOLD + 3; k++) begin
      vectors++;
      if (got !== exp_vec(k, 3, 1'b0)) begin
        miscompares++;
        $display("FAIL start_in_run k=%0d got=%h exp=%h", k, got, exp_vec(k, 3, 1'b0));
      end
      if (k == 2 || k == 3 * HOLD - 1) begin
        start = 1'b1; num_steps = SW'(1); loop_en = 1'b1;
      end
      tick;
      start = 1'b0;
    end
    // num_steps beyond DEPTH clamps
    do_start(200, 1'b0);
    for (int k = 0; k < DEPTH * HOLD + 2; k++) begin
      vectors++;
      if (got !== exp_vec(k, 200, 1'b0)) begin
        miscompares++;
        $display("FAIL clamp k=%0d got=%h exp=%h", k, got, exp_vec(k, 200, 1'b0));
      end
      tick;
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 40; r++) begin
      int  n, total, abort_at, limit;
      bit  lp;
      n  = $urandom_range(0, 6);
      lp = 1'($urandom_range(0, 1));
      for (int s = 0; s < n; s++) wr_script(s, OPW'($urandom_range(0, 63)));
      total = n * HOLD;
      if (lp && n > 0) abort_at = $urandom_range(1, 3 * total);
      else if ($urandom_range(0, 2) == 0) abort_at = $urandom_range(0, total + 1);
      else abort_at = -1;
      limit = (abort_at >= 0) ? abort_at : total + 2;
      do_start(n, lp);
      for (int k = 0; k <= limit; k++) begin
        vectors++;
        if (got !== exp_vec(k, n, lp)) begin
          miscompares++;
          $display("FAIL rand r=%0d k=%0d got=%h exp=%h", r, k, got, exp_vec(k, n, lp));
        end
        if (k == abort_at) begin
          abort = 1'b1; start = 1'($urandom_range(0, 1));
          tick;
          abort = 1'b0; start = 1'b0;
          vectors++;
          if (got !== '0) begin
            miscompares++;
            $display("FAIL rand_abort r=%0d got=%h exp=0", r, got);
          end
        end else if (k < limit) begin
          bit             lw, sw;
          int             li;
          logic [DW-1:0]  ld;
          logic [OPW-1:0] so;
          start     = ((k < total) || (lp && n > 0)) && ($urandom_range(0, 7) == 0);
          num_steps = SW'($urandom);
          loop_en   = 1'($urandom);
          lw = ($urandom_range(0, 3) == 0);
          li = $urandom_range(0, 15);
          ld = rand_dw();
          lane_wr_en = lw; lane_wr_idx = LIW'(li); lane_wr_data = ld;
          // only rewrite the last step while it has not been fetched yet
          sw = (n >= 2) && (k <= (n - 1) * HOLD - 2) && ($urandom_range(0, 3) == 0);
          so = OPW'($urandom_range(0, 63));
          scr_wr_en = sw; scr_wr_addr = AW'(n - 1); scr_wr_op = so;
          tick;
          start = 1'b0; lane_wr_en = 1'b0; scr_wr_en = 1'b0;
          if (lw && li >= 1 && li < NLANES) lanes_m[li] = ld;
          if (sw) script_m[n-1] = so;
        end
      end
      tick;
    end
  endtask

`ifdef XOOD_SEQ_STALL_EN
  task automatic test_stall;
    int            exp_s[$];
    int            total, s;
    logic [VW-1:0] ev;
    logic [OPW-1:0] op;
    for (int a = 0; a < 3; a++) wr_script(a, OPW'($urandom_range(0, 63)));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < HOLD + ((i == 1) ? 3 : 0); j++) exp_s.push_back(i);
    total = exp_s.size();
    do_start(3, 1'b0);
    for (int k = 0; k < total + 2; k++) begin
      ev = '0;
      if (k < total) begin
        s  = exp_s[k];
        op = script_m[s];
        ev = {1'b1, 1'b0, (k == 0 || exp_s[k] != exp_s[k-1]), AW'(s), op,
              lane_model(int'(op[3:0]))};
      end else if (k == total) begin
        ev[VW-2] = 1'b1;
      end
      vectors++;
      if (got !== ev) begin
        miscompares++;
        $display("FAIL stall k=%0d got=%h exp=%h", k, got, ev);
      end
      stall = (k >= HOLD + 1) && (k <= HOLD + 3);
      tick;
    end
    stall = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    scr_wr_en = 1'b0; scr_wr_addr = '0; scr_wr_op = '0;
    lane_wr_en = 1'b0; lane_wr_idx = '0; lane_wr_data = '0;
    num_steps = '0; loop_en = 1'b0; start = 1'b0; abort = 1'b0;
`ifdef XOOD_SEQ_STALL_EN
    stall = 1'b0;
`endif
    for (int i = 0; i < NLANES; i++) lanes_m[i] = '0;
    test_reset();
    test_basic();
    test_hash_mask();
    test_loop_abort();
    test_edge();
    test_random();
`ifdef XOOD_SEQ_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/xood_cmd_sequencer.md
Name: xood_cmd_sequencer

Overview:
- Synthesizable, parametrised command sequencer that drives a Xoodyak core (opmode plus 352-bit input data) from a programmable script.
- Replaces the hardwired opmode ROM and down-counter with loadable script RAM, loadable data lanes and configurable per-step hold length (4/5/12-clock core variants).
- Adds start/done handshake, abort, looping and step tracking.
- Sits between a host/config bus and xoodyak_build.

Parameters:
- DEPTH, 128, number of script entries
- HOLD_CLKS, 4, clocks each script step is presented to the core (>=1)
- OPW, 6, opmode width; bits [3:0] select the data lane
- NLANES, 9, number of data lanes (lane 0 = idle/zero data)
- DW, 352, data lane width

Ports:
- eph1  in  1  clock
- reset  in  1  asynchronous active-high reset
- scr_wr_en  in  1  script write strobe
- scr_wr_addr  in  $clog2(DEPTH)  script write address
- scr_wr_op  in  OPW  opmode stored at scr_wr_addr
- lane_wr_en  in  1  data lane write strobe
- lane_wr_idx  in  $clog2(NLANES)  lane index
- lane_wr_data  in  DW  lane contents
- num_steps  in  $clog2(DEPTH)+1  script length used by a run (sampled at start)
- loop_en  in  1  restart at step 0 after the last step (sampled at start)
- start  in  1  begin run (ignored unless IDLE or DONE)
- abort  in  1  terminate run
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of a non-looping run
- opmode_o  out  OPW  opmode to core
- input_data_o  out  DW  data to core
- step_idx_o  out  $clog2(DEPTH)  current step
- step_first_o  out  1  high on first clock of each step

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, opmode_o=0, input_data_o=0, step_idx_o=0, step_first_o=0, hold counter=0. Script RAM and lanes are not reset; lane 0 always reads zero and ignores writes.
- States:
  - IDLE: outputs 0. start with num_steps!=0 -> RUN at step 0, hold=HOLD_CLKS-1. start with num_steps==0 -> DONE directly, with done pulse.
  - RUN: opmode_o=script[step]. input_data_o=lane[opmode_o[3:0]], or 0 if index>=NLANES. hold decrements each clock. At hold==0:
    - step<num_steps-1: step+1, reload hold.
    - last step, loop_en=1: step=0, reload hold.
    - last step, loop_en=0: -> DONE.
  - DONE: outputs 0, done=1 for exactly the entry cycle. start -> RUN as from IDLE.
- Latency: outputs are registered. First step appears the clock after start is sampled, and each step is held exactly HOLD_CLKS clocks, so a run lasts num_steps*HOLD_CLKS clocks.
- step_first_o=1 on the clock the step's outputs first appear.
- abort: -> IDLE next clock from any state, outputs 0, no done pulse. abort and start in the same cycle: abort wins.
- start while RUN is ignored. num_steps and loop_en are captured at start; later changes are ignored until the next start.
- Writes during RUN:
  - Script write to an address: takes effect if that step has not yet been fetched.
  - Lane write: visible on input_data_o the clock after the write.
- num_steps>DEPTH is clamped to DEPTH.
- HOLD_CLKS==1: hold counter is omitted and the step advances every clock.

Optional Feature:
- XOOD_SEQ_STALL_EN defined: adds input port stall (1 bit). While stall=1 in RUN, the hold counter and step freeze and outputs stay constant; step_first_o is not re-asserted on release. abort still works during stall.
- Undefined: no stall port; the sequence advances unconditionally.

Decomposition:
- Package xood_seq_pkg:
  - state enum {S_IDLE,S_RUN,S_DONE}
  - OP_IDLE='0
  - lane index constants (L_IDLE=0, L_KEY=1, L_NONCE=2, L_ASSOC=3, L_PLAIN=4, L_CIPHER=5, L_SQZ=6, L_RAT=7, L_SKY=8)
  - default DW=352
- Sub-module xood_seq_holdctr: HOLD_CLKS-parametrised down-counter with load/stall/expire, instantiated once.

Test Plan:
- Reset mid-run: load 3 steps {0x01,0x02,0x03}, start, assert reset on cycle 5 -> all outputs 0 immediately and state IDLE.
- Basic run: HOLD_CLKS=4, lanes 1..3 = key/nonce/abs, script {0x01,0x02,0x03}, num_steps=3, start -> opmode_o 0x01 for 4 clks with key data, then 0x02 for 4 clks, then 0x03 for 4 clks; done pulse at clock 13; busy high for 12 clocks.
- Hash opmode masking: script {0x10,0x13}, lane3=abs -> 0x10 drives zero data (lane 0); 0x13 drives abs data; opmode_o carries the full 6 bits.
- Loop plus abort: loop_en=1, num_steps=2, HOLD_CLKS=5 -> step_idx_o sequence 0,0,0,0,0,1,1,1,1,1,0,...; abort on clock 17 -> IDLE next clock, no done pulse.
- Edge cases: num_steps=0 start -> done pulse next clock, busy stays 0. Opmode 0x0F with NLANES=9 -> input_data_o=0. Start during RUN is ignored.
- With XOOD_SEQ_STALL_EN: stall 3 clocks during step 1 -> that step is presented for HOLD_CLKS+3 clocks and total run time grows by 3.
